serial_demux_16: RTL and testbench
==================================

Name: serial_demux_16

Overview:
- Serial-to-parallel block: the receiving end of the bit-select path driven by mux_16x1.
- Takes one bit per accepted beat and steers it into slot n of a 16-bit word, where n is a running 4-bit index (the demux select).
- Presents each completed word on a valid/ready output port.
- Sits between a serial bit source (mux_16x1 driven by a select counter) and any parallel consumer.

Parameters:
- WIDTH, 16, word width in bits; must be a power of 2, minimum 2.
- IDX_W, 4, index width; equals log2(WIDTH).
- LSB_FIRST, 1, 1: the nth accepted bit goes to out_data[n]; 0: the nth accepted bit goes to out_data[WIDTH-1-n].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_sync  input  1  qualified by in_valid; marks this bit as bit 0 of a new word.
- in_ready  output  1  block accepts in_bit this cycle.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer takes out_data this cycle.
- bit_idx  output  IDX_W  index the next accepted bit will occupy (before the LSB_FIRST mapping).
- frame_err  output  1  sticky flag: in_sync arrived mid-word.
- err_clr  input  1  clears frame_err.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_data=0, out_valid=0, bit_idx=0, frame_err=0.
  - Internal accumulator acc=0.
  - Reset asserted mid-word discards the partial word with no output.
- Accept condition: acc_en = in_valid && in_ready.
- in_ready:
  - Combinational: in_ready = !(bit_idx==WIDTH-1 && out_valid && !out_ready).
  - The block stalls only when the last bit would complete a word and the output slot is still occupied.
  - A path from out_ready to in_ready is permitted.
- Bit placement on acc_en:
  - Position p = bit_idx when LSB_FIRST=1, WIDTH-1-bit_idx when LSB_FIRST=0.
  - acc[p] <= in_bit; bit_idx <= bit_idx+1, wrapping WIDTH-1 -> 0.
- Word completion (acc_en with bit_idx==WIDTH-1):
  - Same edge: out_data <= acc with slot p replaced by in_bit; out_valid <= 1; acc <= 0.
  - Latency: the word is visible the cycle after its last bit is accepted.
  - Back-to-back words at 1 bit/cycle with out_ready=1 run with zero bubbles.
- Output handshake:
  - out_valid && out_ready with no simultaneous completion: out_valid <= 0. out_data keeps its value; it is don't-care while out_valid=0.
  - Simultaneous drain and completion: out_valid stays 1 and out_data takes the new word.
  - out_data is stable while out_valid && !out_ready.
- in_sync handling (only when acc_en):
  - bit_idx==0: normal, no error.
  - bit_idx!=0: frame_err <= 1; partial acc cleared; the current bit is stored as bit 0; bit_idx <= 1.
  - in_sync without in_valid is ignored.
- frame_err:
  - Cleared by err_clr.
  - err_clr and a new error in the same cycle: the set wins.
- No other states exist. Control is bit_idx plus out_valid.
  - Conceptual FSM: FILL (out_valid=0) and FULL (out_valid=1); transitions as above.

Decomposition:
- Package serial_demux_pkg:
  - Localparams DEMUX_WIDTH=16 and DEMUX_IDX_W=4.
  - A function mapping index to bit position for LSB_FIRST.
- One natural sub-module: bit_index_ctr.
  - IDX_W-bit wrapping counter with enable and sync-load-to-1 input.
  - Also used as the select generator driving mux_16x1 in loopback.
- Everything else is inline.

Test Plan:
- Loopback: mux_16x1 in=16'hACF1, sel counted 0..15 by bit_index_ctr, in_valid=1, out_ready=1.
  - Required: out_valid pulses 1 cycle after the 16th bit with out_data=16'hACF1.
  - Required: bit_idx steps 0..15 then wraps to 0.
- LSB_FIRST=0, bits 1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,1 in that order.
  - Required: out_data=16'hACF1; first bit lands in out_data[15].
- Backpressure: two words 16'h1234 then 16'hBEEF, out_ready=0.
  - Required: in_ready=0 at bit_idx=15 of word 2; out_data holds 16'h1234.
  - Then out_ready=1 for 1 cycle: 16'h1234 consumed, then 16'hBEEF appears next cycle, with no bits lost.
- Sync mid-word: 5 bits, then in_sync with the next bit followed by 15 bits of 16'h00FF.
  - Required: frame_err=1 and out_data=16'h00FF (partial word dropped).
  - err_clr pulse -> frame_err=0.
  - err_clr in the same cycle as a new error -> frame_err stays 1.
- Reset mid-word: 7 bits accepted, then rst_n=0 asynchronously mid-cycle.
  - Required: out_valid=0, bit_idx=0 and out_data=0 immediately.
  - The next 16 bits (16'h5A5A) produce exactly one word, 16'h5A5A.
- Streaming: 4 consecutive words 16'h0001, 16'h8000, 16'hFFFF, 16'h0000 at 1 bit/cycle, out_ready=1.
  - Required: in_ready never deasserts.
  - Required: out_valid is high on cycles 17, 33, 49, 65 with the words in order.

Source files
------------

// File: rtl/serial_demux_pkg.sv
// serial_demux_pkg: shared widths, control states and index-to-bit mapping for the serial demux
package serial_demux_pkg;
    localparam int DEMUX_WIDTH = 16;
    localparam int DEMUX_IDX_W = 4;
    typedef enum logic {FILL, FULL} demux_state_e;
    function automatic int unsigned bit_pos(input int unsigned idx, input int unsigned width, input bit lsb_first);
        return lsb_first ? idx : width - 1 - idx;
    endfunction
endpackage

// File: rtl/serial_demux_16_if.sv
// serial_demux_16_if: serial bit input, parallel word output and error flag bundle
interface serial_demux_16_if import serial_demux_pkg::*; #(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int IDX_W = DEMUX_IDX_W
);
    logic             in_bit;
    logic             in_valid;
    logic             in_sync;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] bit_idx;
    logic             frame_err;
    logic             err_clr;
    modport master (
        output in_bit, in_valid, in_sync, out_ready, err_clr,
        input  in_ready, out_data, out_valid, bit_idx, frame_err
    );
    modport slave (
        input  in_bit, in_valid, in_sync, out_ready, err_clr,
        output in_ready, out_data, out_valid, bit_idx, frame_err
    );
endinterface

// File: rtl/serial_demux_16_bit_index_ctr.sv
// bit_index_ctr: wrapping index counter with enable and a resync load to 1
module bit_index_ctr import serial_demux_pkg::*; #(
    parameter int IDX_W = DEMUX_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load1,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] idx_d, idx_q;
    always_comb begin
        idx_d = load1 ? IDX_W'(1) : en ? idx_q + IDX_W'(1) : idx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end
    assign idx = idx_q;
endmodule

// File: rtl/serial_demux_16.sv
// serial_demux_16: steers accepted serial bits into a word and presents it on a valid/ready port
module serial_demux_16 import serial_demux_pkg::*; #(
    parameter int WIDTH     = DEMUX_WIDTH,
    parameter int IDX_W     = DEMUX_IDX_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst_n,
    serial_demux_16_if.slave bus
);
    demux_state_e     state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, word;
    logic             frame_err_q, frame_err_d;
    logic [IDX_W-1:0] bit_idx, pos, pos0;
    logic             last, acc_en, resync, complete;
    assign last     = bit_idx == IDX_W'(WIDTH - 1);
    assign bus.in_ready = !(last && state_q == FULL && !bus.out_ready);
    assign acc_en   = bus.in_valid && bus.in_ready;
    // A sync mid-word restarts the frame, so it never completes a word even at the last index.
    assign resync   = acc_en && bus.in_sync && bit_idx != '0;
    assign complete = acc_en && last && !resync;
    assign pos      = IDX_W'(bit_pos(32'(bit_idx), WIDTH, LSB_FIRST));
    assign pos0     = IDX_W'(bit_pos(0, WIDTH, LSB_FIRST));
    bit_index_ctr #(.IDX_W(IDX_W)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_en),
        .load1 (resync),
        .idx   (bit_idx)
    );
    always_comb begin
        word      = acc_q;
        word[pos] = bus.in_bit;
        acc_d     = acc_q;
        if (resync) begin
            acc_d       = '0;
            acc_d[pos0] = bus.in_bit;
        end else if (complete) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = word;
        end
        out_data_d  = complete ? word : out_data_q;
        state_d     = complete ? FULL : (state_q == FULL && bus.out_ready) ? FILL : state_q;
        frame_err_d = resync ? 1'b1 : bus.err_clr ? 1'b0 : frame_err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            acc_q       <= '0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            frame_err_q <= frame_err_d;
        end
    end
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = state_q == FULL;
    assign bus.bit_idx   = bit_idx;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_demux_16.sv
// tb_serial_demux_16: directed scoreboard bench for serial_demux_16 in both bit orders
module tb_serial_demux_16;
    import serial_demux_pkg::*;
    logic clk, rst_n;
    logic a_bit, a_valid, a_sync, a_ordy, a_clr;
    logic b_bit, b_valid;
    logic lb_mode;
    logic [15:0] lb_word;
    logic [3:0]  sel;
    logic [15:0] q[$];
    logic [15:0] exp_w;
    logic [15:0] sw[4];
    logic [15:0] bseq;
    int n_cmp, n_err;

    serial_demux_16_if #(.WIDTH(16), .IDX_W(4)) a_if ();
    serial_demux_16_if #(.WIDTH(16), .IDX_W(4)) b_if ();

    assign a_if.in_bit    = lb_mode ? lb_word[sel] : a_bit;
    assign a_if.in_valid  = lb_mode | a_valid;
    assign a_if.in_sync   = a_sync;
    assign a_if.out_ready = a_ordy;
    assign a_if.err_clr   = a_clr;
    assign b_if.in_bit    = b_bit;
    assign b_if.in_valid  = b_valid;
    assign b_if.in_sync   = 1'b0;
    assign b_if.out_ready = 1'b1;
    assign b_if.err_clr   = 1'b0;

    serial_demux_16 #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    serial_demux_16 #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    bit_index_ctr #(.IDX_W(4)) u_sel (
        .clk(clk), .rst_n(rst_n), .en(lb_mode && a_if.in_ready), .load1(1'b0), .idx(sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            a_bit   = w[i];
            a_valid = 1'b1;
            @(posedge clk);
            #1;
            a_sync  = 1'b0;
        end
        a_valid = 1'b0;
    endtask

    // Scoreboard: each word handed over on a_if is checked against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            chk("sb_word_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_w = q.pop_front();
                chk("sb_word", 32'(a_if.out_data), 32'(exp_w));
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; lb_mode = 1'b0; lb_word = 16'hACF1;
        a_bit = 1'b0; a_valid = 1'b0; a_sync = 1'b0; a_ordy = 1'b1; a_clr = 1'b0;
        b_bit = 1'b0; b_valid = 1'b0;
        sw[0] = 16'h0001; sw[1] = 16'h8000; sw[2] = 16'hFFFF; sw[3] = 16'h0000;
        bseq = 16'hACF1;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_data", 32'(a_if.out_data), 0);
        chk("rst_out_valid", 32'(a_if.out_valid), 0);
        chk("rst_bit_idx", 32'(a_if.bit_idx), 0);
        chk("rst_frame_err", 32'(a_if.frame_err), 0);
        chk("rst_in_ready", 32'(a_if.in_ready), 1);

        q.push_back(16'hACF1);
        lb_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("lb_bit_idx", 32'(a_if.bit_idx), 32'(i));
            chk("lb_no_early_valid", 32'(a_if.out_valid), 0);
            @(posedge clk); #1;
        end
        lb_mode = 1'b0;
        chk("lb_out_valid", 32'(a_if.out_valid), 1);
        chk("lb_out_data", 32'(a_if.out_data), 32'h0000ACF1);
        chk("lb_idx_wrap", 32'(a_if.bit_idx), 0);
        @(posedge clk); #1;
        chk("lb_valid_pulse", 32'(a_if.out_valid), 0);

        for (int i = 0; i < 16; i++) begin
            b_bit   = bseq[15 - i];
            b_valid = 1'b1;
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        chk("msb_out_valid", 32'(b_if.out_valid), 1);
        chk("msb_out_data", 32'(b_if.out_data), 32'h0000ACF1);
        chk("msb_first_bit_15", 32'(b_if.out_data[15]), 1);
        @(posedge clk); #1;

        a_ordy = 1'b0;
        q.push_back(16'h1234);
        send_a(16'h1234, 16);
        chk("bp_word1_valid", 32'(a_if.out_valid), 1);
        q.push_back(16'hBEEF);
        send_a(16'hBEEF, 15);
        a_bit = 1'b1;
        a_valid = 1'b1;
        #1;
        chk("bp_in_ready_low", 32'(a_if.in_ready), 0);
        chk("bp_bit_idx", 32'(a_if.bit_idx), 15);
        chk("bp_hold_data", 32'(a_if.out_data), 32'h00001234);
        @(posedge clk); #1;
        chk("bp_stall_idx", 32'(a_if.bit_idx), 15);
        chk("bp_stall_data", 32'(a_if.out_data), 32'h00001234);
        a_ordy = 1'b1;
        #1;
        chk("bp_ready_path", 32'(a_if.in_ready), 1);
        @(posedge clk); #1;
        a_ordy = 1'b0;
        a_valid = 1'b0;
        chk("bp_word2_valid", 32'(a_if.out_valid), 1);
        chk("bp_word2_data", 32'(a_if.out_data), 32'h0000BEEF);
        chk("bp_word2_idx", 32'(a_if.bit_idx), 0);
        a_ordy = 1'b1;
        @(posedge clk); #1;
        chk("bp_drained", 32'(a_if.out_valid), 0);

        send_a(16'hFFFF, 5);
        q.push_back(16'h00FF);
        a_sync = 1'b1;
        send_a(16'h00FF, 16);
        chk("sync_frame_err", 32'(a_if.frame_err), 1);
        chk("sync_out_data", 32'(a_if.out_data), 32'h000000FF);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("err_clr", 32'(a_if.frame_err), 0);
        send_a(16'h0000, 3);
        a_clr = 1'b1;
        a_sync = 1'b1;
        send_a(16'h0000, 1);
        a_clr = 1'b0;
        chk("err_set_wins", 32'(a_if.frame_err), 1);
        chk("sync_idx_one", 32'(a_if.bit_idx), 1);

        send_a(16'h007F, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(a_if.out_valid), 0);
        chk("arst_bit_idx", 32'(a_if.bit_idx), 0);
        chk("arst_out_data", 32'(a_if.out_data), 0);
        chk("arst_frame_err", 32'(a_if.frame_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        q.push_back(16'h5A5A);
        send_a(16'h5A5A, 16);
        chk("arst_word_valid", 32'(a_if.out_valid), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) q.push_back(sw[i]);
        for (int k = 0; k < 64; k++) begin
            a_bit   = sw[k / 16][k % 16];
            a_valid = 1'b1;
            #1;
            chk("stream_in_ready", 32'(a_if.in_ready), 1);
            chk("stream_out_valid", 32'(a_if.out_valid), 32'(k != 0 && k % 16 == 0));
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        chk("stream_last_valid", 32'(a_if.out_valid), 1);
        chk("stream_last_data", 32'(a_if.out_data), 0);
        @(posedge clk); #1;
        chk("stream_done", 32'(a_if.out_valid), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
